// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount out as single coins (20/10/5 cents)
// from three finite tubes. It selects greedily, tracks the tube inventory and
// reports either exact completion (done) or a rejection/shortfall (err).
module change_dispenser #(
  parameter int N20_INIT = 8,
  parameter int N10_INIT = 8,
  parameter int N5_INIT  = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [5:0]       amount,
  input  logic             refill,
  input  logic             coin_ack,
  output logic             busy,
  output logic             coin_valid,
  output logic [4:0]       coin_val,
  output logic             done,
  output logic             err,
  output logic [5:0]       rem,
  output logic [CNT_W-1:0] cnt20,
  output logic [CNT_W-1:0] cnt10,
  output logic [CNT_W-1:0] cnt5
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EMIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] INIT20 = CNT_W'(N20_INIT);
  localparam logic [CNT_W-1:0] INIT10 = CNT_W'(N10_INIT);
  localparam logic [CNT_W-1:0] INIT5  = CNT_W'(N5_INIT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t     state, state_n;
  logic [4:0] pick;
  logic [4:0] coin_val_n;
  logic       amount_ok;
  logic       ack_now;
  logic       last_coin;

  // Payout amount is accepted only if it is a multiple of 5 within 0..60.
  always_comb begin
    amount_ok = (amount <= 6'd60) && ((amount % 6'd5) == 6'd0);
  end

  // Greedy choice: largest in-stock coin that does not exceed the remainder.
  always_comb begin
    pick = 5'd0;
    if (rem >= 6'd20 && cnt20 != '0)      pick = 5'd20;
    else if (rem >= 6'd10 && cnt10 != '0) pick = 5'd10;
    else if (rem >= 6'd5 && cnt5 != '0)   pick = 5'd5;
  end

  // Next-state and next coin presentation.
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    coin_val_n = 5'd0;
    ack_now    = 1'b0;
    last_coin  = (rem == {1'b0, coin_val});
    case (state)
      S_IDLE: begin
        if (req) state_n = amount_ok ? S_SELECT : S_ERR;
      end
      S_SELECT: begin
        if (rem == 6'd0) begin
          state_n = S_DONE;
        end else if (pick != 5'd0) begin
          state_n    = S_EMIT;
          coin_val_n = pick;
        end else begin
          state_n = S_ERR;
        end
      end
      S_EMIT: begin
        if (coin_ack) begin
          ack_now = 1'b1;
          // The final coin goes straight to DONE; no extra SELECT is needed.
          state_n = last_coin ? S_DONE : S_SELECT;
        end else begin
          coin_val_n = coin_val;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs; outputs are derived from the next state so
  // they line up with the state they describe.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      coin_valid <= 1'b0;
      coin_val   <= 5'd0;
      done       <= 1'b0;
      err        <= 1'b0;
      rem        <= 6'd0;
    end else begin
      state      <= state_n;
      busy       <= (state_n != S_IDLE);
      coin_valid <= (state_n == S_EMIT);
      coin_val   <= coin_val_n;
      done       <= (state_n == S_DONE);
      err        <= (state_n == S_ERR);
      if (state == S_IDLE && req)  rem <= amount;
      else if (ack_now)            rem <= rem - {1'b0, coin_val};
    end
  end

  // Tube inventory: refill only in IDLE, decrement on each acknowledged coin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt20 <= INIT20;
      cnt10 <= INIT10;
      cnt5  <= INIT5;
    end else if (state == S_IDLE && refill) begin
      cnt20 <= INIT20;
      cnt10 <= INIT10;
      cnt5  <= INIT5;
    end else if (ack_now) begin
      case (coin_val)
        5'd20:   cnt20 <= cnt20 - ONE;
        5'd10:   cnt10 <= cnt10 - ONE;
        5'd5:    cnt5  <= cnt5 - ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: drives payouts with random ack delays and compares the
// coin stream, result, remainder, inventory and cycle timing against a
// behavioural model computed from plain coin arithmetic.
module tb_change_dispenser;

  localparam int INIT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [5:0] amount;
  logic       refill;
  logic       coin_ack;
  logic       busy;
  logic       coin_valid;
  logic [4:0] coin_val;
  logic       done;
  logic       err;
  logic [5:0] rem;
  logic [3:0] cnt20, cnt10, cnt5;

  int n_pass  = 0;
  int n_total = 0;

  // model inventory and expectations
  int m20, m10, m5;
  int exp_q[$];
  bit exp_ok;
  int exp_rem;

  change_dispenser #(
    .N20_INIT(INIT), .N10_INIT(INIT), .N5_INIT(INIT), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .amount(amount), .refill(refill),
    .coin_ack(coin_ack), .busy(busy), .coin_valid(coin_valid),
    .coin_val(coin_val), .done(done), .err(err), .rem(rem),
    .cnt20(cnt20), .cnt10(cnt10), .cnt5(cnt5)
  );

  always #5 clk = ~clk;

  // Reference: validity check, then greedy change-making from finite stock.
  task automatic model(input int amt);
    int r;
    exp_q.delete();
    if (amt > 60 || (amt % 5) != 0) begin
      exp_ok  = 1'b0;
      exp_rem = amt;
      return;
    end
    r = amt;
    while (r > 0) begin
      if (r >= 20 && m20 > 0)      begin exp_q.push_back(20); m20--; r -= 20; end
      else if (r >= 10 && m10 > 0) begin exp_q.push_back(10); m10--; r -= 10; end
      else if (r >= 5 && m5 > 0)   begin exp_q.push_back(5);  m5--;  r -= 5;  end
      else break;
    end
    exp_ok  = (r == 0);
    exp_rem = r;
  endtask

  // Runs one payout starting at a negedge; returns at the IDLE negedge after
  // the done/err pulse, so a following call exercises back-to-back requests.
  task automatic do_payout(input int amt, input bit rf, input bit tied,
                           input int first_delay, input bit inject);
    int got_q[$];
    int cyc_q[$];
    int cyc, end_cyc, waitc, delay, exp_end;
    bit fin, got_done, got_err, invalid;
    logic [4:0] held;
    invalid = (amt > 60 || (amt % 5) != 0);
    if (rf) begin m20 = INIT; m10 = INIT; m5 = INIT; end
    model(amt);
    coin_ack = tied;
    req = 1'b1; amount = 6'(amt); refill = rf;
    @(posedge clk); #1;
    req = 1'b0; refill = 1'b0; amount = 6'($urandom_range(0, 63));
    cyc = 0; fin = 0; waitc = 0; delay = first_delay; end_cyc = 0;
    got_done = 0; got_err = 0; held = '0;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        n_total++;
        if (busy !== 1'b1) $display("FAIL busy_rise amt=%0d got=%b want=1", amt, busy);
        else n_pass++;
      end
      if (inject && cyc == 3) begin req = 1'b1; amount = 6'd5; refill = 1'b1; end
      if (inject && cyc == 4) begin req = 1'b0; refill = 1'b0; end
      if (coin_valid) begin
        if (waitc == 0) held = coin_val;
        else begin
          n_total++;
          if (coin_val !== held) $display("FAIL coin_stable got=%0d want=%0d", coin_val, held);
          else n_pass++;
        end
        if (tied || waitc >= delay) begin
          coin_ack = 1'b1;
          got_q.push_back(int'(coin_val));
          cyc_q.push_back(cyc);
          waitc = 0;
          delay = tied ? 0 : int'($urandom_range(0, 3));
        end else begin
          coin_ack = 1'b0;
          waitc++;
        end
      end else begin
        coin_ack = tied;
      end
      if (done || err) begin
        fin = 1; got_done = done; got_err = err; end_cyc = cyc;
      end
    end
    n_total++;
    if (!fin) begin
      $display("FAIL timeout amt=%0d no done/err within %0d cycles", amt, cyc);
      return;
    end
    n_pass++;
    n_total++;
    if (got_done !== exp_ok || got_err !== !exp_ok)
      $display("FAIL result amt=%0d got done=%b err=%b want done=%b", amt, got_done, got_err, exp_ok);
    else n_pass++;
    n_total++;
    if (got_q != exp_q) $display("FAIL coin_seq amt=%0d got=%p want=%p", amt, got_q, exp_q);
    else n_pass++;
    if (tied) begin
      if (invalid) exp_end = 1;
      else if (exp_ok) exp_end = (exp_q.size() == 0) ? 2 : 2 * exp_q.size() + 1;
      else exp_end = 2 * exp_q.size() + 2;
      n_total++;
      if (end_cyc != exp_end) $display("FAIL end_cycle amt=%0d got=%0d want=%0d", amt, end_cyc, exp_end);
      else n_pass++;
      foreach (cyc_q[i]) begin
        n_total++;
        if (cyc_q[i] != 2 * i + 2) $display("FAIL coin_cycle amt=%0d idx=%0d got=%0d want=%0d", amt, i, cyc_q[i], 2 * i + 2);
        else n_pass++;
      end
    end
    @(negedge clk);
    coin_ack = 1'b0;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || coin_valid !== 1'b0)
      $display("FAIL idle_after amt=%0d busy=%b done=%b err=%b cv=%b want all 0", amt, busy, done, err, coin_valid);
    else n_pass++;
    n_total++;
    if (int'(rem) != exp_rem) $display("FAIL rem amt=%0d got=%0d want=%0d", amt, rem, exp_rem);
    else n_pass++;
    n_total++;
    if (int'(cnt20) != m20 || int'(cnt10) != m10 || int'(cnt5) != m5)
      $display("FAIL counts amt=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", amt, cnt20, cnt10, cnt5, m20, m10, m5);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; amount = '0; refill = 1'b0; coin_ack = 1'b0;
    m20 = INIT; m10 = INIT; m5 = INIT;
    repeat (3) @(negedge clk);
    n_total++;
    if (busy !== 0 || coin_valid !== 0 || coin_val !== 0 || done !== 0 || err !== 0 || rem !== 0)
      $display("FAIL reset_outputs busy=%b cv=%b val=%0d done=%b err=%b rem=%0d want 0", busy, coin_valid, coin_val, done, err, rem);
    else n_pass++;
    n_total++;
    if (cnt20 !== 4'(INIT) || cnt10 !== 4'(INIT) || cnt5 !== 4'(INIT))
      $display("FAIL reset_counts got=%0d/%0d/%0d want=%0d each", cnt20, cnt10, cnt5, INIT);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_payout(35, 0, 1, 0, 0);
  endtask

  task automatic test_no_twenties();
    do_payout(60, 0, 1, 0, 0);
    do_payout(60, 0, 1, 0, 0);
    do_payout(20, 0, 1, 0, 0);
    do_payout(20, 0, 1, 0, 0);
  endtask

  task automatic test_shortfall();
    do_payout(60, 1, 1, 0, 0);
    do_payout(60, 0, 1, 0, 0);
    do_payout(40, 0, 1, 0, 0);
    do_payout(60, 0, 1, 0, 0);
    do_payout(20, 0, 1, 0, 0);
    do_payout(35, 0, 1, 0, 0);
    do_payout(15, 0, 1, 0, 0);
  endtask

  task automatic test_invalid_and_zero();
    do_payout(7, 1, 1, 0, 0);
    do_payout(0, 0, 1, 0, 0);
    do_payout(63, 0, 1, 0, 0);
    do_payout(60, 0, 1, 0, 0);
  endtask

  task automatic test_stall();
    do_payout(30, 1, 0, 5, 1);
  endtask

  task automatic test_reset_mid();
    int guard;
    coin_ack = 1'b0;
    req = 1'b1; amount = 6'd35; refill = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    guard = 0;
    while (coin_valid !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    n_total++;
    if (coin_valid !== 1'b1) $display("FAIL mid_reset_setup coin_valid never rose");
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (coin_valid !== 0 || busy !== 0 || coin_val !== 0 || rem !== 0 || done !== 0 || err !== 0)
      $display("FAIL mid_reset_outputs cv=%b busy=%b val=%0d rem=%0d want 0", coin_valid, busy, coin_val, rem);
    else n_pass++;
    n_total++;
    if (cnt20 !== 4'(INIT) || cnt10 !== 4'(INIT) || cnt5 !== 4'(INIT))
      $display("FAIL mid_reset_counts got=%0d/%0d/%0d want=%0d each", cnt20, cnt10, cnt5, INIT);
    else n_pass++;
    m20 = INIT; m10 = INIT; m5 = INIT;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_payout(5, 0, 1, 0, 0);
  endtask

  task automatic test_random();
    int amt;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 5) == 0) amt = int'($urandom_range(0, 63));
      else amt = 5 * int'($urandom_range(0, 12));
      do_payout(amt, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_twenties();
    test_shortfall();
    test_invalid_and_zero();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
